// File: rtl/height_sqrt_seq_pkg.sv
// Shared types and widths for the height square-root stage and its consumers.
// W_OUT doubles as the result width and the number of restoring iterations.
package height_sqrt_seq_pkg;
  localparam int DEF_W_IN = 8;
  localparam int DEF_FRAC = 4;
  localparam int DEF_W_OUT = DEF_W_IN/2 + DEF_FRAC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/height_sqrt_seq_if.sv
// Height-in / t_fall-out handshake bundle.
interface height_sqrt_seq_if #(
  parameter int W_IN  = 8,
  parameter int W_OUT = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [W_IN-1:0]   height;
  logic              out_valid;
  logic              out_ready;
  logic [W_OUT-1:0]  t_fall;
  logic              busy;

  modport slave  (input in_valid, height, out_ready,
                  output in_ready, out_valid, t_fall, busy);
  modport master (output in_valid, height, out_ready,
                  input in_ready, out_valid, t_fall, busy);
endinterface

// File: rtl/height_sqrt_seq_sqrt_step.sv
// One restoring square-root iteration: bring down a bit pair, try (root<<2)|1.
module sqrt_step #(
  parameter int W = 8
) (
  input  logic [W+1:0] rem,
  input  logic [W-1:0] root,
  input  logic [1:0]   pair,
  output logic [W+1:0] rem_nxt,
  output logic [W-1:0] root_nxt
);
  logic [W+1:0] rem_sh, trial;
  logic         ge;

  // rem never exceeds 2*root, so dropping its top bits on the shift is lossless
  assign rem_sh   = (rem << 2) | (W+2)'(pair);
  assign trial    = {root, 2'b01};
  assign ge       = (rem_sh >= trial);
  assign rem_nxt  = ge ? rem_sh - trial : rem_sh;
  assign root_nxt = (root << 1) | W'(ge);
endmodule

// File: rtl/height_sqrt_seq.sv
// Sequential t_fall = round(sqrt(height) * 2^FRAC), one result bit per clock,
// with a final rounding cycle before the result is offered downstream.
module height_sqrt_seq
  import height_sqrt_seq_pkg::*;
#(
  parameter int W_IN = DEF_W_IN,
  parameter int FRAC = DEF_FRAC
) (
  input logic          clk,
  input logic          rst_n,
  height_sqrt_seq_if.slave bus
);
  localparam int W_OUT = W_IN/2 + FRAC;
  localparam int W_RAD = 2*W_OUT;
  localparam int CW    = $clog2(W_OUT+1);
  localparam logic [CW-1:0] LAST = CW'(W_OUT);

  state_e             state, state_nxt;
  logic [W_RAD-1:0]   rad;
  logic [W_OUT+1:0]   rem, rem_nxt;
  logic [W_OUT-1:0]   root, root_nxt, t_fall_q;
  logic [CW-1:0]      cnt;
  logic               accept, round_up;

  assign accept        = bus.in_valid && (state == ST_IDLE);
  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.t_fall    = t_fall_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.in_valid)  state_nxt = ST_CALC;
      ST_CALC: if (cnt == LAST)   state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  sqrt_step #(.W(W_OUT)) u_step (
    .rem      (rem),
    .root     (root),
    .pair     (rad[W_RAD-1 -: 2]),
    .rem_nxt  (rem_nxt),
    .root_nxt (root_nxt)
  );

  // rem - root^2 > root  <=>  sqrt lies at or above root + 0.5
  assign round_up = (rem > {2'b00, root});

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rad      <= '0;
      rem      <= '0;
      root     <= '0;
      cnt      <= '0;
      t_fall_q <= '0;
    end else if (accept) begin
      rad  <= {bus.height, {(2*FRAC){1'b0}}};
      rem  <= '0;
      root <= '0;
      cnt  <= '0;
    end else if (state == ST_CALC) begin
      if (cnt != LAST) begin
        rad  <= rad << 2;
        rem  <= rem_nxt;
        root <= root_nxt;
        cnt  <= cnt + 1'b1;
      end else begin
        t_fall_q <= root + W_OUT'(round_up);
      end
    end
endmodule

// File: tb/tb_height_sqrt_seq.sv
// Directed + sweep bench for height_sqrt_seq; expected results go into a
// scoreboard queue at accept time and a monitor pops them on each handshake.
module tb_height_sqrt_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  height_sqrt_seq_if #(.W_IN(8), .W_OUT(8)) bus ();

  height_sqrt_seq #(.W_IN(8), .FRAC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;
  logic [7:0] exp_q[$];
  int         acc_q[$];
  logic       prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] ref_sqrt(input int h);
    real r;
    r = $sqrt(real'(h * 256)) + 0.5;
    return 8'($rtoi(r));
  endfunction

  // Monitor: latency on each rising out_valid, value on each handshake.
  always @(negedge clk) begin
    if (!rst_n) prev_valid <= 1'b0;
    else begin
      if (bus.out_valid && !prev_valid) begin
        if (acc_q.size() == 0) chk("unexpected_valid", 1, 0);
        else chk("latency", cyc - acc_q.pop_front(), 9);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", int'(bus.t_fall), -1);
        else chk("t_fall", int'(bus.t_fall), int'(exp_q.pop_front()));
      end
      prev_valid <= bus.out_valid;
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [7:0] h, input logic [7:0] expv);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.height   = h;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 300) begin
        chk("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(expv);
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); n++;
    end
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  logic [7:0] bp_h [6] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd100, 8'd255};
  logic [7:0] bp_e [6] = '{8'h00, 8'h10, 8'h17, 8'h1C, 8'hA0, 8'hFF};
  logic sweep_done = 1'b0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.height    = '0;
    bus.out_ready = 1'b1;

    // reset / idle
    cycles(3);
    rst_n = 1'b1;
    cycles(1);
    chk("rst_in_ready",  int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy",      int'(bus.busy), 0);
    chk("rst_t_fall",    int'(bus.t_fall), 0);

    // basic values
    for (int i = 0; i < 6; i++) begin
      send(bp_h[i], bp_e[i]);
      if (i == 4) begin
        chk("calc_busy",     int'(bus.busy), 1);
        chk("calc_in_ready", int'(bus.in_ready), 0);
      end
    end
    drain();

    // back-pressure with a competing sample held on the input
    bus.out_ready = 1'b0;
    send(8'd2, 8'h17);
    bus.in_valid = 1'b1;
    bus.height   = 8'd100;
    cycles(20);
    chk("bp_out_valid", int'(bus.out_valid), 1);
    chk("bp_t_fall",    int'(bus.t_fall), 8'h17);
    chk("bp_in_ready",  int'(bus.in_ready), 0);
    chk("bp_pending",   acc_q.size() + exp_q.size(), 1);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    cycles(1);
    chk("bp_rel_out_valid", int'(bus.out_valid), 0);
    chk("bp_rel_in_ready",  int'(bus.in_ready), 1);

    // in_valid pulse during CALC is ignored
    send(8'd3, 8'h1C);
    cycles(2);
    bus.in_valid = 1'b1;
    bus.height   = 8'd255;
    cycles(1);
    bus.in_valid = 1'b0;
    cycles(15);
    chk("ign_no_extra", exp_q.size() + acc_q.size(), 0);

    // reset in the middle of CALC
    send(8'd200, 8'hE2);
    cycles(3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  int'(bus.in_ready), 1);
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_busy",      int'(bus.busy), 0);
    chk("mid_rst_t_fall",    int'(bus.t_fall), 0);
    exp_q.delete();
    acc_q.delete();
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    send(8'd200, 8'hE2);
    drain();

    // full sweep with random downstream stalls
    fork
      begin
        for (int h = 0; h < 256; h++) send(8'(h), ref_sqrt(h));
        drain();
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end
endmodule
